exec_mc_sched: RTL

Sequencer for the multi-cycle execution resources of the execute stage: MUL, DIV, FADD, FSUB, FSQRT and the UART IN/OUT path.
- Accepts one issue per instruction from decode and holds the pipeline with a stall while the selected unit's fixed latency counts down (or while the UART path reports busy).
- Then emits a one-cycle writeback strobe carrying the destination register.
- Single-cycle ops pass through with no stall. A perf counter tracks total stall cycles.

---
 rtl/exec_mc_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/exec_mc_sched.sv
// Execute-stage sequencer for multi-cycle units (MUL/DIV/FADD/FSUB/FSQRT/UART).
// Stalls the pipeline while the selected unit's latency elapses, then strobes writeback.
module exec_mc_sched #(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned DIV_LAT   = 36,
  parameter int unsigned FADD_LAT  = 2,
  parameter int unsigned FSUB_LAT  = 2,
  parameter int unsigned FSQRT_LAT = 4,
  parameter int unsigned CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue,
  input  logic [2:0]  unit,
  input  logic [4:0]  rd,
  input  logic [1:0]  rw,
  input  logic        hazard,
  input  logic        flush,
  input  logic        uart_busy,
  output logic        stall,
  output logic        op_fire,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_rw,
  output logic        busy,
  output logic [2:0]  cur_unit,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [2:0] U_MUL   = 3'd1;
  localparam logic [2:0] U_DIV   = 3'd2;
  localparam logic [2:0] U_FADD  = 3'd3;
  localparam logic [2:0] U_FSUB  = 3'd4;
  localparam logic [2:0] U_FSQRT = 3'd5;
  localparam logic [2:0] U_UART  = 3'd6;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       rw_q, rw_d;
  logic [2:0]       unit_q, unit_d;
  logic             op_fire_q, op_fire_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             is_mc;
  logic             accept;

  function automatic logic [CNT_W-1:0] lat_minus1(input logic [2:0] u);
    case (u)
      U_MUL:   return CNT_W'(MUL_LAT - 1);
      U_DIV:   return CNT_W'(DIV_LAT - 1);
      U_FADD:  return CNT_W'(FADD_LAT - 1);
      U_FSUB:  return CNT_W'(FSUB_LAT - 1);
      U_FSQRT: return CNT_W'(FSQRT_LAT - 1);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets its default before any branch, so no latch is inferred.
    is_mc       = (unit != 3'd0) && (unit != 3'd7);
    accept      = (state_q == IDLE) && issue && !hazard && !flush && is_mc;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    unit_d      = unit_q;
    op_fire_d   = 1'b0;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = WAIT;
            rd_d      = rd;
            rw_d      = rw;
            unit_d    = unit;
            cnt_d     = (unit == U_UART) ? '0 : lat_minus1(unit);
            op_fire_d = 1'b1;
          end
        end
        WAIT: begin
          if (unit_q == U_UART) begin
            if (!uart_busy) state_d = DONE;
          // The accept cycle is the first latency cycle, so WAIT lasts LAT-1 cycles (at least one).
          end else if (cnt_q <= CNT_W'(1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    stall       = accept || (state_q == WAIT);
    stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      rw_q        <= '0;
      unit_q      <= '0;
      op_fire_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      unit_q      <= unit_d;
      op_fire_q   <= op_fire_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A flush in DONE kills the strobe in the same cycle.
  assign wb_valid  = (state_q == DONE) && !flush;
  assign op_fire   = op_fire_q;
  assign wb_rd     = rd_q;
  assign wb_rw     = rw_q;
  assign busy      = (state_q != IDLE);
  assign cur_unit  = unit_q;
  assign stall_cnt = stall_cnt_q;

endmodule
